// File: rtl/multi_trigger_scaler_if.sv
// Discriminator inputs, per-channel controls and scaler readout of multi_trigger_scaler.
// master drives channel levels/controls, slave is the conditioner itself.
interface multi_trigger_scaler_if #(
    parameter int NCH   = 16,
    parameter int WIDTH = 16,
    parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]   trig_i;
    logic [NCH-1:0]   power_i;
    logic [NCH-1:0]   mask_i;
    logic             slow_ce_i;
    logic [SELW-1:0]  scaler_sel_i;
    logic [NCH-1:0]   trig_o;
    logic [NCH-1:0]   stuck_o;
    logic [WIDTH-1:0] scaler_dat_o;
    logic             scaler_update_o;

    modport master (
        output trig_i, power_i, mask_i, slow_ce_i, scaler_sel_i,
        input  trig_o, stuck_o, scaler_dat_o, scaler_update_o
    );

    modport slave (
        input  trig_i, power_i, mask_i, slow_ce_i, scaler_sel_i,
        output trig_o, stuck_o, scaler_dat_o, scaler_update_o
    );
endinterface

// File: rtl/multi_trigger_scaler.sv
// Per-channel synchroniser, non-retriggerable one-shot, saturating scaler and stuck-high detector.
// Latency: trig_o SYNC_CYCLES+1 cycles after the input edge, readout 1 cycle; free-running, no backpressure.
module multi_trigger_scaler #(
    parameter int NCH             = 16,
    parameter int WIDTH           = 16,
    parameter int SYNC_CYCLES     = 2,
    parameter int ONE_SHOT_LENGTH = 3,
    parameter int STUCK_PERIODS   = 4,
    parameter int SELW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multi_trigger_scaler_if.slave bus
);
    localparam int OSW = $clog2(ONE_SHOT_LENGTH + 1);
    localparam int SCW = $clog2(STUCK_PERIODS + 1);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [OSW-1:0]   OS_LOAD   = OSW'(ONE_SHOT_LENGTH);
    localparam logic [SCW-1:0]   STUCK_MAX = SCW'(STUCK_PERIODS);

    logic [SYNC_CYCLES-1:0] sync_q      [NCH];
    logic [OSW-1:0]         os_q        [NCH];
    logic [WIDTH-1:0]       cnt_q       [NCH];
    logic [WIDTH-1:0]       hold_q      [NCH];
    logic [SCW-1:0]         stuck_cnt_q [NCH];
    logic [NCH-1:0]         dly_q;
    logic [NCH-1:0]         allhigh_q;
    logic [NCH-1:0]         trig_q;
    logic [WIDTH-1:0]       dat_q;
    logic                   upd_q;

    logic [NCH-1:0]         level;
    logic [NCH-1:0]         edge_det;
    logic [SCW-1:0]         stuck_cnt_nxt [NCH];
    logic [SELW-1:0]        sel;

    assign sel = bus.scaler_sel_i;

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            level[ch]         = sync_q[ch][SYNC_CYCLES-1];
            edge_det[ch]      = level[ch] & ~dly_q[ch];
            stuck_cnt_nxt[ch] = '0;
            // A period only counts towards stuck if L never dropped, including its last cycle.
            if (allhigh_q[ch] && level[ch]) begin
                stuck_cnt_nxt[ch] = (stuck_cnt_q[ch] == STUCK_MAX) ? STUCK_MAX
                                                                  : stuck_cnt_q[ch] + SCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NCH; ch++) begin
                sync_q[ch]      <= '0;
                os_q[ch]        <= '0;
                cnt_q[ch]       <= '0;
                hold_q[ch]      <= '0;
                stuck_cnt_q[ch] <= '0;
            end
            dly_q     <= '0;
            allhigh_q <= '0;
            trig_q    <= '0;
            dat_q     <= '0;
            upd_q     <= 1'b0;
        end else begin
            upd_q <= bus.slow_ce_i;
            dat_q <= (int'(sel) < NCH) ? hold_q[sel] : '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!bus.power_i[ch]) begin
                    sync_q[ch]      <= '0;
                    os_q[ch]        <= '0;
                    cnt_q[ch]       <= '0;
                    hold_q[ch]      <= '0;
                    stuck_cnt_q[ch] <= '0;
                    dly_q[ch]       <= 1'b0;
                    allhigh_q[ch]   <= 1'b0;
                    trig_q[ch]      <= 1'b0;
                end else begin
                    sync_q[ch] <= {sync_q[ch][SYNC_CYCLES-2:0], bus.trig_i[ch]};
                    dly_q[ch]  <= level[ch];

                    // Output follows the loaded counter one cycle later, giving exactly
                    // ONE_SHOT_LENGTH high cycles; edges while busy are dropped.
                    trig_q[ch] <= (os_q[ch] != '0) && !bus.mask_i[ch];
                    if (os_q[ch] != '0) begin
                        os_q[ch] <= os_q[ch] - OSW'(1);
                    end else if (edge_det[ch]) begin
                        os_q[ch] <= OS_LOAD;
                    end

                    if (bus.slow_ce_i) begin
                        hold_q[ch]      <= (stuck_cnt_nxt[ch] == STUCK_MAX) ? CNT_MAX : cnt_q[ch];
                        cnt_q[ch]       <= WIDTH'(edge_det[ch]);
                        stuck_cnt_q[ch] <= stuck_cnt_nxt[ch];
                        allhigh_q[ch]   <= 1'b1;
                    end else begin
                        if (edge_det[ch] && (cnt_q[ch] != CNT_MAX)) begin
                            cnt_q[ch] <= cnt_q[ch] + WIDTH'(1);
                        end
                        if (!level[ch]) begin
                            allhigh_q[ch] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            bus.stuck_o[ch] = (stuck_cnt_q[ch] == STUCK_MAX);
        end
    end

    assign bus.trig_o          = trig_q;
    assign bus.scaler_dat_o    = dat_q;
    assign bus.scaler_update_o = upd_q;
endmodule

// File: tb/tb_multi_trigger_scaler.sv
// Bench for multi_trigger_scaler: a 16-channel/16-bit and a 12-channel/4-bit instance share stimulus
// and are checked every cycle against an edge-indexed history model, plus directed corner cases.
module tb_multi_trigger_scaler;
    localparam int SYNC = 2;
    localparam int OSL  = 3;
    localparam int STP  = 4;
    localparam int NCH_OF [2] = '{16, 12};
    localparam int MAX_OF [2] = '{65535, 15};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] trig, power, mask;
    logic        slow_ce;
    logic [3:0]  sel;

    int checks = 0;
    int errors = 0;

    multi_trigger_scaler_if #(.NCH(16), .WIDTH(16)) bus_a ();
    multi_trigger_scaler_if #(.NCH(12), .WIDTH(4))  bus_b ();

    assign bus_a.trig_i       = trig;
    assign bus_a.power_i      = power;
    assign bus_a.mask_i       = mask;
    assign bus_a.slow_ce_i    = slow_ce;
    assign bus_a.scaler_sel_i = sel;
    assign bus_b.trig_i       = trig[11:0];
    assign bus_b.power_i      = power[11:0];
    assign bus_b.mask_i       = mask[11:0];
    assign bus_b.slow_ce_i    = slow_ce;
    assign bus_b.scaler_sel_i = sel;

    multi_trigger_scaler #(.NCH(16), .WIDTH(16)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    multi_trigger_scaler #(.NCH(12), .WIDTH(4))  dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Reference model: input history indexed by clock edge; a channel sees its input SYNC edges
    // late, and only if it has been powered and out of reset for that whole span.
    logic [15:0] hist [$];
    int          last_off [16];
    int          t = 0;
    int          start_m [2][16];
    int          cnt_m   [2][16];
    int          hold_m  [2][16];
    bit          ah_m    [2][16];
    int          ps_m    [2][16];
    logic [15:0] exp_trig  [2];
    logic [15:0] exp_stuck [2];
    int          exp_dat   [2];
    bit          exp_upd;

    function automatic bit lvl(input int ch, input int at);
        logic [15:0] h;
        if (at - SYNC < 0 || at - SYNC <= last_off[ch]) return 1'b0;
        h = hist[at - SYNC];
        return h[ch];
    endfunction

    task automatic model_step();
        bit lt, lp, e, off;
        for (int k = 0; k < 2; k++) begin
            if (rst || int'(sel) >= NCH_OF[k]) exp_dat[k] = 0;
            else                               exp_dat[k] = hold_m[k][sel];
        end
        exp_upd = !rst && slow_ce;
        hist.push_back(trig);
        for (int ch = 0; ch < 16; ch++) begin
            lt  = lvl(ch, t);
            lp  = lvl(ch, t - 1);
            e   = lt && !lp;
            off = rst || !power[ch];
            for (int k = 0; k < 2; k++) begin
                if (ch < NCH_OF[k]) begin
                    if (off) begin
                        start_m[k][ch] = -100;
                        cnt_m[k][ch]   = 0;
                        hold_m[k][ch]  = 0;
                        ah_m[k][ch]    = 1'b0;
                        ps_m[k][ch]    = 0;
                    end else begin
                        if (e && t > start_m[k][ch] + OSL) start_m[k][ch] = t;
                        if (slow_ce) begin
                            if (ah_m[k][ch] && lt) ps_m[k][ch] = (ps_m[k][ch] + 1 > STP) ? STP : ps_m[k][ch] + 1;
                            else                   ps_m[k][ch] = 0;
                            hold_m[k][ch] = (ps_m[k][ch] == STP) ? MAX_OF[k] : cnt_m[k][ch];
                            cnt_m[k][ch]  = e ? 1 : 0;
                            ah_m[k][ch]   = 1'b1;
                        end else begin
                            if (e && cnt_m[k][ch] < MAX_OF[k]) cnt_m[k][ch]++;
                            if (!lt) ah_m[k][ch] = 1'b0;
                        end
                    end
                    exp_trig[k][ch]  = !off && !mask[ch] && (start_m[k][ch] < t) && (t <= start_m[k][ch] + OSL);
                    exp_stuck[k][ch] = (ps_m[k][ch] == STP);
                end
            end
            if (off) last_off[ch] = t;
        end
        t++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, t - 1, act, exp);
        end
    endtask

    task automatic compare();
        check("model trig_a",  32'(bus_a.trig_o),          32'(exp_trig[0]));
        check("model trig_b",  32'(bus_b.trig_o),          32'(exp_trig[1][11:0]));
        check("model stuck_a", 32'(bus_a.stuck_o),         32'(exp_stuck[0]));
        check("model stuck_b", 32'(bus_b.stuck_o),         32'(exp_stuck[1][11:0]));
        check("model dat_a",   32'(bus_a.scaler_dat_o),    exp_dat[0]);
        check("model dat_b",   32'(bus_b.scaler_dat_o),    exp_dat[1]);
        check("model upd_a",   32'(bus_a.scaler_update_o), 32'(exp_upd));
        check("model upd_b",   32'(bus_b.scaler_update_o), 32'(exp_upd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    typedef struct {
        logic        trig0;
        logic        ce;
        logic [15:0] exp_trig;
        logic        exp_upd;
        logic [15:0] exp_dat;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   rises, highs, lim, ce_cd;
        bit   prev, seen;

        for (int ch = 0; ch < 16; ch++) begin
            last_off[ch] = -1000;
            for (int k = 0; k < 2; k++) begin
                start_m[k][ch] = -100; cnt_m[k][ch] = 0; hold_m[k][ch] = 0;
                ah_m[k][ch] = 1'b0; ps_m[k][ch] = 0;
            end
        end
        exp_trig = '{16'h0, 16'h0};
        exp_stuck = '{16'h0, 16'h0};

        // trig_i[0] high for 2 cycles: trig_o[0] high for exactly 3 cycles, then readout of count 1
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 16'h0001, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 16'h0001, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 16'h0001, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'd0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'd1};

        rst = 1'b1; trig = '0; power = '1; mask = '0; slow_ce = 1'b0; sel = '0;
        repeat (3) tick();
        check("reset trig_o",  32'(bus_a.trig_o),          0);
        check("reset stuck_o", 32'(bus_a.stuck_o),         0);
        check("reset dat",     32'(bus_a.scaler_dat_o),    0);
        check("reset update",  32'(bus_a.scaler_update_o), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            trig[0] = tbl[i].trig0;
            slow_ce = tbl[i].ce;
            tick();
            check("table trig_o", 32'(bus_a.trig_o),          32'(tbl[i].exp_trig));
            check("table stuck",  32'(bus_a.stuck_o),         0);
            check("table update", 32'(bus_a.scaler_update_o), 32'(tbl[i].exp_upd));
            check("table dat",    32'(bus_a.scaler_dat_o),    32'(tbl[i].exp_dat));
        end
        slow_ce = 1'b0;

        // Retrigger: 5 highs on ch1 two cycles apart -> 3 non-extended pulses, count 5
        rises = 0; highs = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            trig[1] = (i < 10) && (i % 2 == 0);
            tick();
            if (bus_a.trig_o[1] && !prev) rises++;
            if (bus_a.trig_o[1]) highs++;
            prev = bus_a.trig_o[1];
        end
        check("retrig pulses", rises, 3);
        check("retrig highs",  highs, 9);
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        sel = 4'd1; tick();
        check("retrig count", 32'(bus_a.scaler_dat_o), 5);

        // 20 edges on ch0: 16-bit reads 20, 4-bit saturates at 15
        for (int i = 0; i < 43; i++) begin
            trig[0] = (i < 40) && (i % 2 == 0);
            tick();
        end
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        sel = 4'd0; tick();
        check("count 20 edges", 32'(bus_a.scaler_dat_o), 20);
        check("saturate 4bit",  32'(bus_b.scaler_dat_o), 15);

        // Edge landing on slow_ce belongs to the new period
        trig[0] = 1'b1; tick(); tick();
        slow_ce = 1'b1; tick(); slow_ce = 1'b0; trig[0] = 1'b0;
        tick();
        check("coincident old period", 32'(bus_a.scaler_dat_o), 0);
        repeat (3) tick();
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        tick();
        check("coincident new period a", 32'(bus_a.scaler_dat_o), 1);
        check("coincident new period b", 32'(bus_b.scaler_dat_o), 1);

        // Stuck: ch2 high through 4 full periods
        trig[2] = 1'b1; repeat (3) tick();
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            repeat (5) tick();
            slow_ce = 1'b1; tick(); slow_ce = 1'b0;
            check("stuck flag", 32'(bus_a.stuck_o[2]), (p == 4) ? 1 : 0);
        end
        sel = 4'd2; tick();
        check("stuck hold a", 32'(bus_a.scaler_dat_o), 32'hFFFF);
        check("stuck hold b", 32'(bus_b.scaler_dat_o), 32'hF);
        trig[2] = 1'b0; tick(); trig[2] = 1'b1;
        repeat (5) tick();
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        check("stuck released", 32'(bus_a.stuck_o[2]), 0);
        trig[2] = 1'b0;

        // Mask keeps counting but silences trig_o; power-off clears; power-on sees one edge
        mask[3] = 1'b1; seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            trig[3] = (i < 6) && (i % 2 == 0);
            tick();
            if (bus_a.trig_o[3]) seen = 1'b1;
        end
        check("masked trig_o", 32'(seen), 0);
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        sel = 4'd3; tick();
        check("masked count", 32'(bus_a.scaler_dat_o), 3);
        power[3] = 1'b0; trig[3] = 1'b1; tick();
        check("power off trig",  32'(bus_a.trig_o[3]),  0);
        check("power off stuck", 32'(bus_a.stuck_o[3]), 0);
        tick();
        check("power off hold", 32'(bus_a.scaler_dat_o), 0);
        power[3] = 1'b1; mask[3] = 1'b0;
        repeat (6) tick();
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        tick();
        check("power on single edge", 32'(bus_a.scaler_dat_o), 1);
        trig[3] = 1'b0;

        // Readout walk, out-of-range select on the 12-channel instance
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s); tick();
        end
        sel = 4'd13; tick();
        check("sel beyond NCH", 32'(bus_b.scaler_dat_o), 0);

        // Reset mid-period discards counts and emits no update
        for (int i = 0; i < 6; i++) begin
            trig[5] = (i % 2 == 0);
            tick();
        end
        trig[5] = 1'b0;
        rst = 1'b1; tick();
        check("mid reset trig",   32'(bus_a.trig_o),          0);
        check("mid reset stuck",  32'(bus_a.stuck_o),         0);
        check("mid reset dat",    32'(bus_a.scaler_dat_o),    0);
        check("mid reset update", 32'(bus_a.scaler_update_o), 0);
        rst = 1'b0; tick();
        check("post reset update", 32'(bus_a.scaler_update_o), 0);
        slow_ce = 1'b1; tick(); slow_ce = 1'b0;
        sel = 4'd5; tick();
        check("discarded count", 32'(bus_a.scaler_dat_o), 0);

        // Random traffic against the model
        ce_cd = 10;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 16; ch++) begin
                lim = (ch == 2 || ch == 7) ? 60 : 3;
                if ($urandom_range(lim - 1, 0) == 0) trig[ch] = ~trig[ch];
                if (power[ch]) begin
                    if ($urandom_range(399, 0) == 0) power[ch] = 1'b0;
                end else if ($urandom_range(19, 0) == 0) begin
                    power[ch] = 1'b1;
                end
                if ($urandom_range(49, 0) == 0) mask[ch] = ~mask[ch];
            end
            ce_cd--;
            slow_ce = (ce_cd == 0);
            if (ce_cd == 0) ce_cd = $urandom_range(50, 4);
            sel = 4'($urandom_range(15, 0));
            rst = ($urandom_range(999, 0) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
